// File: rtl/gerador_estado_frequencia_pkg.sv
// Shared encodings and defaults for the state/frequency generator and the seven-segment decoder.
package gerador_estado_frequencia_pkg;

  // Fixed state encodings; the downstream decoder depends on these exact values.
  localparam logic [1:0] ST_OCIOSO   = 2'b00;
  localparam logic [1:0] ST_OPERANDO = 2'b01;
  localparam logic [1:0] ST_ALARME   = 2'b11;
  localparam logic [1:0] ST_FIM      = 2'b10;

  localparam int unsigned DIV_PADRAO      = 12_500_000;
  localparam int unsigned T_ALARME_PADRAO = 4;

endpackage

// File: rtl/gerador_estado_frequencia_divisor.sv
// Prescaler plus 2-bit animation phase counter with synchronous clear.
module divisor_frequencia
  import gerador_estado_frequencia_pkg::*;
#(
  parameter int unsigned DIV = DIV_PADRAO
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       clr,
  output logic [1:0] freq,
  output logic       passo,
  output logic       tick
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign passo = (cnt == ULTIMO);
  // passo is the raw step used by the FSM; tick is masked in the clearing cycle.
  assign tick  = passo & ~clr;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt  <= '0;
      freq <= '0;
    end else if (clr) begin
      cnt  <= '0;
      freq <= '0;
    end else if (passo) begin
      cnt  <= '0;
      freq <= freq + 2'd1;
    end else begin
      cnt  <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gerador_estado_frequencia.sv
// Control FSM, input synchronisers and alarm counter driving the seven-segment decoder.
module gerador_estado_frequencia
  import gerador_estado_frequencia_pkg::*;
#(
  parameter int unsigned DIV      = DIV_PADRAO,
  parameter int unsigned T_ALARME = T_ALARME_PADRAO
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BTN_INICIO,
  input  logic       BTN_PARA,
  input  logic       SENSOR,
  output logic [1:0] ST,
  output logic [1:0] FREQ,
  output logic       TICK
);

  localparam int unsigned AW = $clog2(T_ALARME + 1);
  localparam logic [AW-1:0] ALVO = AW'(T_ALARME - 1);

  logic [2:0]    sinc_ini, sinc_para;
  logic [1:0]    sinc_sens;
  logic          ev_ini, ev_para, sensor;
  logic [1:0]    prox;
  logic          muda, passo, volta;
  logic [AW-1:0] acnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sinc_ini  <= '0;
      sinc_para <= '0;
      sinc_sens <= '0;
    end else begin
      sinc_ini  <= {sinc_ini[1:0], BTN_INICIO};
      sinc_para <= {sinc_para[1:0], BTN_PARA};
      sinc_sens <= {sinc_sens[0], SENSOR};
    end
  end

  assign ev_ini  = sinc_ini[1] & ~sinc_ini[2];
  assign ev_para = sinc_para[1] & ~sinc_para[2];
  assign sensor  = sinc_sens[1];
  assign volta   = passo & (FREQ == 2'd3);

  always_comb begin
    prox = ST;
    case (ST)
      ST_OCIOSO:   if (ev_ini) prox = ST_OPERANDO;
      ST_OPERANDO: begin
        if (sensor)       prox = ST_ALARME;
        else if (ev_para) prox = ST_OCIOSO;
      end
      // Leave on the edge that completes the last wrap, so FIM starts in step with phase 0.
      ST_ALARME:   if (volta && acnt == ALVO) prox = ST_FIM;
      ST_FIM:      if (ev_ini) prox = ST_OCIOSO;
      default:     prox = ST_OCIOSO;
    endcase
  end

  assign muda = (prox != ST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ST   <= ST_OCIOSO;
      acnt <= '0;
    end else begin
      ST <= prox;
      if (muda)
        acnt <= '0;
      else if (ST == ST_ALARME && volta)
        acnt <= acnt + AW'(1);
    end
  end

  divisor_frequencia #(.DIV(DIV)) u_divisor (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (muda),
    .freq    (FREQ),
    .passo   (passo),
    .tick    (TICK)
  );

endmodule

// File: tb/tb_gerador_estado_frequencia.sv
// Directed bench for gerador_estado_frequencia with DIV=4, T_ALARME=2.
module tb_gerador_estado_frequencia;

  logic       CLK = 1'b0;
  logic       RESET_N, BTN_INICIO, BTN_PARA, SENSOR;
  logic [1:0] ST, FREQ;
  logic       TICK;

  int n_cmp = 0;
  int n_err = 0;

  gerador_estado_frequencia #(.DIV(4), .T_ALARME(2)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .BTN_INICIO (BTN_INICIO),
    .BTN_PARA   (BTN_PARA),
    .SENSOR     (SENSOR),
    .ST         (ST),
    .FREQ       (FREQ),
    .TICK       (TICK)
  );

  always #5 CLK = ~CLK;

  task automatic confere(input string tag, input logic [3:0] obtido, input logic [3:0] esperado);
    n_cmp++;
    if (obtido !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obtido, esperado, $time);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic avanca(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESET_N = 1'b0; BTN_INICIO = 1'b0; BTN_PARA = 1'b0; SENSOR = 1'b0;
    avanca(2);
    confere("rst_st", {2'b0, ST}, 4'd0);
    confere("rst_freq", {2'b0, FREQ}, 4'd0);
    confere("rst_tick", {3'b0, TICK}, 4'd0);

    // 1: free-running phase in OCIOSO
    RESET_N = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      avanca(1);
      confere("t1_st", {2'b0, ST}, 4'd0);
      confere("t1_freq", {2'b0, FREQ}, 4'((k / 4) % 4));
      confere("t1_tick", {3'b0, TICK}, (k % 4 == 3) ? 4'd1 : 4'd0);
    end

    // 2: held start button, 3-edge latency, single transition
    BTN_INICIO = 1'b1;
    avanca(1); confere("t2_st_e1", {2'b0, ST}, 4'd0);
    avanca(1); confere("t2_st_e2", {2'b0, ST}, 4'd0);
    avanca(1); confere("t2_st_e3", {2'b0, ST}, 4'd1);
    confere("t2_freq0", {2'b0, FREQ}, 4'd0);
    confere("t2_tick0", {3'b0, TICK}, 4'd0);
    avanca(1); confere("t2_tick1", {3'b0, TICK}, 4'd0);
    avanca(1); confere("t2_tick2", {3'b0, TICK}, 4'd0);
    avanca(1); confere("t2_tick3", {3'b0, TICK}, 4'd1);
    avanca(1); confere("t2_freq1", {2'b0, FREQ}, 4'd1);
    avanca(3);
    BTN_INICIO = 1'b0;
    for (int k = 0; k < 6; k++) begin
      avanca(1);
      confere("t2_hold", {2'b0, ST}, 4'd1);
    end

    // stop event returns to OCIOSO, then start again
    BTN_PARA = 1'b1; avanca(1); BTN_PARA = 1'b0;
    confere("para_e1", {2'b0, ST}, 4'd1);
    avanca(1); confere("para_e2", {2'b0, ST}, 4'd1);
    avanca(1); confere("para_e3", {2'b0, ST}, 4'd0);
    BTN_INICIO = 1'b1; avanca(1); BTN_INICIO = 1'b0;
    avanca(2); confere("ini2", {2'b0, ST}, 4'd1);
    avanca(2);

    // 3: sensor wins over simultaneous stop
    SENSOR = 1'b1; BTN_PARA = 1'b1;
    avanca(1); confere("t3_e1", {2'b0, ST}, 4'd1);
    avanca(1); confere("t3_e2", {2'b0, ST}, 4'd1);
    avanca(1); confere("t3_e3", {2'b0, ST}, 4'd3);
    confere("t3_freq", {2'b0, FREQ}, 4'd0);
    BTN_PARA = 1'b0;

    // 4: ALARME for two wraps, buttons ignored
    for (int k = 1; k <= 32; k++) begin
      SENSOR = 1'b0;
      BTN_INICIO = (k <= 24) ? k[0] : 1'b0;
      BTN_PARA   = (k <= 24) ? ~k[0] : 1'b0;
      avanca(1);
      if (k < 32) confere("t4_alarme", {2'b0, ST}, 4'd3);
      else begin
        confere("t4_fim", {2'b0, ST}, 4'd2);
        confere("t4_freq", {2'b0, FREQ}, 4'd0);
      end
    end

    // 5: FIM ignores stop, start returns to OCIOSO
    avanca(3);
    BTN_PARA = 1'b1; avanca(1); BTN_PARA = 1'b0;
    avanca(5); confere("t5_para", {2'b0, ST}, 4'd2);
    BTN_INICIO = 1'b1; avanca(1); BTN_INICIO = 1'b0;
    confere("t5_e1", {2'b0, ST}, 4'd2);
    avanca(1); confere("t5_e2", {2'b0, ST}, 4'd2);
    avanca(1); confere("t5_e3", {2'b0, ST}, 4'd0);
    confere("t5_freq", {2'b0, FREQ}, 4'd0);

    // 6: asynchronous reset mid-alarm
    avanca(2);
    BTN_INICIO = 1'b1; avanca(1); BTN_INICIO = 1'b0;
    avanca(2); confere("t6_op", {2'b0, ST}, 4'd1);
    SENSOR = 1'b1;
    avanca(3); confere("t6_al", {2'b0, ST}, 4'd3);
    avanca(11);
    confere("t6_pre_freq", {2'b0, FREQ}, 4'd2);
    confere("t6_pre_tick", {3'b0, TICK}, 4'd1);
    #3; RESET_N = 1'b0; SENSOR = 1'b0;
    #1;
    confere("t6_rst_st", {2'b0, ST}, 4'd0);
    confere("t6_rst_freq", {2'b0, FREQ}, 4'd0);
    confere("t6_rst_tick", {3'b0, TICK}, 4'd0);
    avanca(1);
    RESET_N = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      avanca(1);
      if (k % 8 == 0) confere("t6_idle", {2'b0, ST}, 4'd0);
    end
    confere("t6_end_st", {2'b0, ST}, 4'd0);
    confere("t6_end_freq", {2'b0, FREQ}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
